// File: rtl/flag_unit_if.sv
// Flag unit types and bus interface.
// csr_t is the ALU status word; bit order matches the software write
// layout: [3]=Sign, [2]=Zero, [1]=Carry, [0]=Overflow.
package flag_unit_pkg;
    typedef struct packed {
        logic sign;
        logic zero;
        logic carry;
        logic ovf;
    } csr_t;
endpackage

// Bundles every flag-unit signal except clock and reset.
// Handshake: there is no valid/ready pairing. flag_we, sw_we, push, pop and
// err_clr are single-cycle request strobes sampled at each rising edge and
// always accepted; their effects are visible one cycle later. cond/cond_true
// is a purely combinational query. dbg_count exposes the stack depth.
interface flag_unit_if #(
    parameter int DEPTH = 4
);
    import flag_unit_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    csr_t          alu_csr;
    logic          flag_we;
    logic          sw_we;
    logic [3:0]    sw_wdata;
    logic          push;
    logic          pop;
    logic          err_clr;
    logic [2:0]    cond;
    csr_t          flags;
    logic          cond_true;
    logic          full;
    logic          empty;
    logic          stack_err;
    logic [CW-1:0] dbg_count;

    // Requester side: ALU, software and branch logic.
    modport master (
        output alu_csr, flag_we, sw_we, sw_wdata, push, pop, err_clr, cond,
        input  flags, cond_true, full, empty, stack_err, dbg_count
    );

    // The flag unit itself.
    modport slave (
        input  alu_csr, flag_we, sw_we, sw_wdata, push, pop, err_clr, cond,
        output flags, cond_true, full, empty, stack_err, dbg_count
    );
endinterface

// File: rtl/flag_unit.sv
// Architectural flag register with a small LIFO for interrupt save/restore
// and a branch-condition evaluator working on the registered flags.
module flag_unit
    import flag_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic         clk,
    input logic         rst_n,
    flag_unit_if.slave  bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    csr_t          flags_q, flags_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    csr_t          stack_q [DEPTH];
    csr_t          stack_d [DEPTH];

    logic          full, empty;
    logic          push_ok, push_ovf, pop_ok, pop_unf, swap_ok, restore;
    logic [IW-1:0] wr_idx, top_idx;
    csr_t          top_val;
    logic          cond_true;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Classify the stack request; push+pop on a non-empty stack is a swap.
    always_comb begin
        push_ok  = bus.push & ~bus.pop & ~full;
        push_ovf = bus.push & ~bus.pop & full;
        pop_ok   = bus.pop & ~bus.push & ~empty;
        swap_ok  = bus.pop & bus.push & ~empty;
        pop_unf  = bus.pop & empty;
        restore  = pop_ok | swap_ok;
        wr_idx   = IW'(count_q);
        top_idx  = IW'(count_q - CW'(1));
        top_val  = stack_q[top_idx];
    end

    // Flag register next value: restore, then software write, then ALU.
    always_comb begin
        flags_d = flags_q;
        if (restore) begin
            flags_d = top_val;
        end else if (bus.sw_we) begin
            flags_d = csr_t'(bus.sw_wdata);
        end else if (bus.flag_we) begin
            flags_d = bus.alu_csr;
        end
    end

    // Stack writes always store the pre-edge flag register.
    always_comb begin
        stack_d = stack_q;
        if (push_ok) begin
            stack_d[wr_idx] = flags_q;
        end else if (swap_ok) begin
            stack_d[top_idx] = flags_q;
        end
    end

    // Depth counter; swaps and error events leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (push_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    // Sticky error; a new overflow/underflow wins over a same-cycle clear.
    always_comb begin
        err_d = err_q;
        if (push_ovf | pop_unf) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end
    end

    // Branch condition against the registered flags only.
    always_comb begin
        cond_true = 1'b0;
        case (bus.cond)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = flags_q.zero;
            3'b010:  cond_true = ~flags_q.zero;
            3'b011:  cond_true = flags_q.carry;
            3'b100:  cond_true = ~flags_q.carry;
            3'b101:  cond_true = flags_q.sign;
            3'b110:  cond_true = flags_q.sign ^ flags_q.ovf;
            3'b111:  cond_true = ~flags_q.zero & (flags_q.sign == flags_q.ovf);
            default: cond_true = 1'b0;
        endcase
    end

    // Control state: flags, depth and error flag, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Stack storage carries no reset; entries above the count are don't-care.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign bus.flags     = flags_q;
    assign bus.cond_true = cond_true;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.stack_err = err_q;
    assign bus.dbg_count = count_q;

endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit: expected state vectors go into a queue as
// each step is driven and are popped and compared after the clock edge.
module tb_flag_unit;
    import flag_unit_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int W     = 4 + 3 + CW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] exp_q[$];
    logic         cond_q[$];

    // Clock
    always #10 clk = ~clk;

    flag_unit_if #(.DEPTH(DEPTH)) bus ();

    flag_unit #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] st(input logic [3:0] f, input logic fu,
                                        input logic em, input logic er, input int cnt);
        return {f, fu, em, er, CW'(cnt)};
    endfunction

    function automatic logic [W-1:0] observed();
        return {bus.flags, bus.full, bus.empty, bus.stack_err, bus.dbg_count};
    endfunction

    function automatic logic cond_model(input logic [3:0] f, input logic [2:0] c);
        logic s, z, cy, o;
        {s, z, cy, o} = f;
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return cy;
            3'd4:    return !cy;
            3'd5:    return s;
            3'd6:    return s != o;
            default: return !z && (s == o);
        endcase
    endfunction

    task automatic idle();
        bus.alu_csr  = '0;
        bus.flag_we  = 1'b0;
        bus.sw_we    = 1'b0;
        bus.sw_wdata = 4'b0000;
        bus.push     = 1'b0;
        bus.pop      = 1'b0;
        bus.err_clr  = 1'b0;
    endtask

    task automatic check_state(input string tag);
        logic [W-1:0] e;
        logic [W-1:0] o;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed=no-expectation expected=queued-state", tag);
        end else begin
            e = exp_q.pop_front();
            o = observed();
            assert (o === e) else begin
                errors++;
                $error("FAIL %s: observed=%b expected=%b (flags,full,empty,err,count)", tag, o, e);
            end
        end
    endtask

    // Queue the expected post-edge state, clock once, compare, then go idle.
    task automatic tick(input string tag, input logic [W-1:0] exp);
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check_state(tag);
        idle();
    endtask

    task automatic check_cond(input string tag, input logic [2:0] c, input logic exp);
        logic e;
        bus.cond = c;
        cond_q.push_back(exp);
        #1;
        e = cond_q.pop_front();
        checks++;
        assert (bus.cond_true === e) else begin
            errors++;
            $error("FAIL %s cond=%b: observed=%b expected=%b", tag, c, bus.cond_true, e);
        end
    endtask

    task automatic sw(input logic [3:0] v);
        bus.sw_we    = 1'b1;
        bus.sw_wdata = v;
    endtask

    initial begin
        logic [7:0] rst_cond;
        logic [3:0] v;
        rst_cond = 8'b1001_0101;
        idle();
        bus.cond = 3'b000;

        // Reset values and reset-time branch conditions
        rst_n = 1'b0;
        #5;
        exp_q.push_back(st(4'b0000, 1'b0, 1'b1, 1'b0, 0));
        check_state("reset");
        for (int c = 0; c < 8; c++) check_cond("reset_cond", 3'(c), rst_cond[c]);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ALU latch and condition evaluation
        bus.flag_we = 1'b1;
        bus.alu_csr = csr_t'(4'b1010);
        tick("alu_latch", st(4'b1010, 1'b0, 1'b1, 1'b0, 0));
        check_cond("alu_latch", 3'b011, 1'b1);
        check_cond("alu_latch", 3'b110, 1'b1);
        check_cond("alu_latch", 3'b111, 1'b0);
        check_cond("alu_latch", 3'b001, 1'b0);

        // Software write beats ALU write
        sw(4'b0100);
        bus.flag_we = 1'b1;
        bus.alu_csr = csr_t'(4'b1111);
        tick("sw_priority", st(4'b0100, 1'b0, 1'b1, 1'b0, 0));
        check_cond("sw_priority", 3'b001, 1'b1);

        // Fill the stack; each push saves the pre-edge flags
        sw(4'b0001);
        tick("fill_init", st(4'b0001, 1'b0, 1'b1, 1'b0, 0));
        bus.push = 1'b1; sw(4'b0010);
        tick("push1", st(4'b0010, 1'b0, 1'b0, 1'b0, 1));
        bus.push = 1'b1; sw(4'b0100);
        tick("push2", st(4'b0100, 1'b0, 1'b0, 1'b0, 2));
        bus.push = 1'b1; sw(4'b1000);
        tick("push3", st(4'b1000, 1'b0, 1'b0, 1'b0, 3));
        bus.push = 1'b1; sw(4'b0000);
        tick("push4_full", st(4'b0000, 1'b1, 1'b0, 1'b0, 4));
        bus.push = 1'b1;
        tick("overflow", st(4'b0000, 1'b1, 1'b0, 1'b1, 4));

        // Drain in LIFO order
        bus.pop = 1'b1;
        tick("pop1", st(4'b1000, 1'b0, 1'b0, 1'b1, 3));
        bus.pop = 1'b1;
        tick("pop2", st(4'b0100, 1'b0, 1'b0, 1'b1, 2));
        bus.pop = 1'b1;
        tick("pop3", st(4'b0010, 1'b0, 1'b0, 1'b1, 1));
        bus.pop = 1'b1;
        tick("pop4_empty", st(4'b0001, 1'b0, 1'b1, 1'b1, 0));
        bus.err_clr = 1'b1;
        tick("err_clr1", st(4'b0001, 1'b0, 1'b1, 1'b0, 0));

        // Underflow while the ALU write still lands
        bus.pop = 1'b1; bus.flag_we = 1'b1; bus.alu_csr = csr_t'(4'b0110);
        tick("underflow_alu", st(4'b0110, 1'b0, 1'b1, 1'b1, 0));
        bus.err_clr = 1'b1;
        tick("err_clr2", st(4'b0110, 1'b0, 1'b1, 1'b0, 0));
        bus.pop = 1'b1; bus.err_clr = 1'b1;
        tick("set_beats_clr", st(4'b0110, 1'b0, 1'b1, 1'b1, 0));
        bus.err_clr = 1'b1;
        tick("err_clr3", st(4'b0110, 1'b0, 1'b1, 1'b0, 0));

        // Swap: top 0011, flags 1100
        sw(4'b0011);
        tick("swap_init", st(4'b0011, 1'b0, 1'b1, 1'b0, 0));
        bus.push = 1'b1; sw(4'b1100);
        tick("swap_push", st(4'b1100, 1'b0, 1'b0, 1'b0, 1));
        bus.push = 1'b1; bus.pop = 1'b1;
        tick("swap", st(4'b0011, 1'b0, 1'b0, 1'b0, 1));
        bus.pop = 1'b1;
        tick("swap_top", st(4'b1100, 1'b0, 1'b1, 1'b0, 0));

        // Swap beats a same-cycle ALU write
        sw(4'b0101);
        tick("swapw_init", st(4'b0101, 1'b0, 1'b1, 1'b0, 0));
        bus.push = 1'b1; sw(4'b1001);
        tick("swapw_push", st(4'b1001, 1'b0, 1'b0, 1'b0, 1));
        bus.push = 1'b1; bus.pop = 1'b1; bus.flag_we = 1'b1; bus.alu_csr = csr_t'(4'b1111);
        tick("swap_alu", st(4'b0101, 1'b0, 1'b0, 1'b0, 1));
        bus.pop = 1'b1;
        tick("swapw_top", st(4'b1001, 1'b0, 1'b1, 1'b0, 0));

        // Push+pop on empty: error, software write still applies
        bus.push = 1'b1; bus.pop = 1'b1; sw(4'b0111);
        tick("swap_empty", st(4'b0111, 1'b0, 1'b1, 1'b1, 0));
        bus.err_clr = 1'b1;
        tick("err_clr4", st(4'b0111, 1'b0, 1'b1, 1'b0, 0));

        // Asynchronous reset with two entries stacked
        sw(4'b0001);
        tick("rst_init", st(4'b0001, 1'b0, 1'b1, 1'b0, 0));
        bus.push = 1'b1;
        tick("rst_push1", st(4'b0001, 1'b0, 1'b0, 1'b0, 1));
        bus.push = 1'b1;
        tick("rst_push2", st(4'b0001, 1'b0, 1'b0, 1'b0, 2));
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(st(4'b0000, 1'b0, 1'b1, 1'b0, 0));
        check_state("async_reset");
        check_cond("async_reset", 3'b010, 1'b1);
        #2;
        rst_n = 1'b1;
        bus.pop = 1'b1;
        tick("pop_after_reset", st(4'b0000, 1'b0, 1'b1, 1'b1, 0));
        bus.err_clr = 1'b1;
        tick("err_clr5", st(4'b0000, 1'b0, 1'b1, 1'b0, 0));

        // Random flag values against every condition code
        for (int n = 0; n < 6; n++) begin
            v = 4'($urandom_range(0, 15));
            sw(v);
            tick("rand_sw", st(v, 1'b0, 1'b1, 1'b0, 0));
            for (int c = 0; c < 8; c++) check_cond("rand_cond", 3'(c), cond_model(v, 3'(c)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flag_unit.md
# flag_unit

Status-flag consumer for the ALU's `csr_t` output. It holds the architectural flag register and latches ALU flags or software writes. It saves and restores flags on a DEPTH-entry LIFO for interrupt entry and return, and evaluates branch conditions against the registered flags. It sits between the ALU and the fetch/branch logic: the ALU produces flags, and this block stores and interprets them.

## Interface
- `DEPTH`, default 4: number of flag-save stack entries; legal range 1..16.

- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `alu_csr` input `csr_t` (Sign, Zero, Carry, Overflow): flags from the ALU.
- `flag_we` input 1: latch `alu_csr` into the flag register.
- `sw_we` input 1: software write of flags from `sw_wdata`.
- `sw_wdata` input 4: bit mapping [3]=Sign, [2]=Zero, [1]=Carry, [0]=Overflow.
- `push` input 1: save the current flag register onto the stack.
- `pop` input 1: restore the flag register from the stack top.
- `err_clr` input 1: clear `stack_err`.
- `cond` input 3: branch condition select.
- `flags` output `csr_t`: current flag register.
- `cond_true` output 1: `cond` evaluated against `flags`.
- `full` output 1: stack holds DEPTH entries.
- `empty` output 1: stack holds 0 entries.
- `stack_err` output 1: sticky overflow/underflow indicator.

## Operation
- Flag register next-value priority, highest first:
  - valid pop restores the stack top;
  - then `sw_we` loads `sw_wdata`;
  - then `flag_we` loads `alu_csr`;
  - otherwise hold.
- Push stores the pre-edge value of `flags` (the value before any same-cycle update). A same-cycle `flag_we` or `sw_we` still updates the register.
- Push alone:
  - not full: write entry [count], count+1;
  - full: no stack change, `stack_err` set.
- Pop alone:
  - not empty: `flags` takes entry [count-1], count-1;
  - empty: no stack or restore change, `stack_err` set; `sw_we`/`flag_we` still apply per priority.
- Push and pop together:
  - not empty: swap. Top entry is overwritten with pre-edge `flags`, `flags` takes the old top, count unchanged, no error.
  - empty: `stack_err` set, count unchanged, `flags` follows `sw_we`/`flag_we`.
- `stack_err`: set on any overflow or underflow event. `err_clr` clears it; a set event in the same cycle wins over `err_clr`.
- `cond` encoding (combinational, uses registered `flags` only, never `alu_csr`):
  - 000: always
  - 001: Zero
  - 010: !Zero
  - 011: Carry
  - 100: !Carry
  - 101: Sign
  - 110: Sign != Overflow (signed less)
  - 111: !Zero && (Sign == Overflow) (signed greater)
- Counter width is $clog2(DEPTH+1); `full` = (count == DEPTH), `empty` = (count == 0). Both are decoded from registered count. Entry contents beyond count are don't-care.

## Timing
- Reset (asynchronous, on `rst_n` low): `flags`=0000, count=0, `empty`=1, `full`=0, `stack_err`=0. Stack entries are not reset.
- `cond_true` during reset follows `flags`=0: 1 for `cond` 000, 010, 100, 111; 0 otherwise.
- All register updates take effect at the next rising edge; `flags`, `full`, `empty` and `stack_err` change one cycle after the request.
- `cond_true` has zero-cycle latency from `cond`. It reflects a `flag_we` one cycle after that write.
- Reset asserted mid-sequence discards all stack contents; the first cycle after deassertion behaves as empty.

## Test plan
- Reset, then `flag_we` with `alu_csr`={S=1,Z=0,C=1,O=0} -> next cycle `flags`=1010, `cond`=011 gives `cond_true`=1, `cond`=110 gives 1, `cond`=111 gives 0.
- `sw_we`=1 with `sw_wdata`=0100 and `flag_we`=1 with `alu_csr`=1111, same cycle -> `flags`=0100.
- DEPTH=4: push with `flags`=0001, 0010, 0100, 1000 -> `full`=1. A fifth push -> `stack_err`=1, count stays 4. Four pops -> `flags` = 1000, 0100, 0010, 0001 in that order, then `empty`=1.
- Empty stack: pop with `flag_we` and `alu_csr`=0110 -> `stack_err`=1, `flags`=0110. `err_clr` -> `stack_err`=0 next cycle.
- Stack top 0011, `flags`=1100: push+pop together -> `flags`=0011, top=1100, count unchanged.
- Push+pop and `flag_we` together -> `flags` = old top, because pop has priority over `flag_we`.
- Assert `rst_n`=0 asynchronously with 2 entries -> outputs return to reset values before the next edge; a pop after release -> `stack_err`=1.
